// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the iterative multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // ALUOp encoding that selects MUL; control unit and ALU control decode the same value
    localparam logic [1:0] MULT_OPCODE    = 2'b11;
    localparam int         DEFAULT_DATA_W = 32;

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-add datapath: operand registers, accumulator, iteration counter
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] acc,
    output logic              mplier_zero_next,
    output logic              last
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load) begin
            mcand_d  = operand_a;
            mplier_d = operand_b;
            acc_d    = '0;
            count_d  = '0;
        end else if (step) begin
            // Sum wraps at DATA_W bits; only the low half of the product is kept
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign acc              = acc_q;
    assign mplier_zero_next = ((mplier_q >> 1) == '0);
    assign last             = (count_q == LAST_CNT);

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - MUL sequencing FSM: stalls the front pipeline and pulses done on completion
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    mult_state_t state_q, state_d;
    logic        load;
    logic        step;
    logic        mplier_zero_next;
    logic        last;

    mult_shift_add_dp #(
        .DATA_W(DATA_W)
    ) u_dp (
        .clk              (clk),
        .arst_n           (arst_n),
        .load             (load),
        .step             (step),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .acc              (result),
        .mplier_zero_next (mplier_zero_next),
        .last             (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    stall = 1'b1;
                    if (last || (EARLY_EXIT && mplier_zero_next)) begin
                        state_d = DONE;
                    end
                end
            end
            // start here still belongs to the finishing MUL, so it is not re-accepted
            DONE: begin
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - scoreboard bench for mult_sequencer, full-length and early-exit builds
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] operand_a, operand_b;
    logic        start_f, flush_f, stall_f, busy_f, done_f;
    logic        start_e, flush_e, stall_e, busy_e, done_e;
    logic [31:0] result_f, result_e;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_f[$];
    logic [31:0] q_e[$];

    always #5 clk = ~clk;

    mult_sequencer #(.DATA_W(32), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .arst_n(arst_n), .start(start_f), .flush(flush_f),
        .operand_a(operand_a), .operand_b(operand_b),
        .stall(stall_f), .busy(busy_f), .done(done_f), .result(result_f)
    );

    mult_sequencer #(.DATA_W(32), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .arst_n(arst_n), .start(start_e), .flush(flush_e),
        .operand_a(operand_a), .operand_b(operand_b),
        .stall(stall_e), .busy(busy_e), .done(done_e), .result(result_e)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_k(input logic [31:0] b, input bit early);
        if (!early) return 32;
        for (int i = 31; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    function automatic logic get_stall(input bit sel);
        return sel ? stall_e : stall_f;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done_e : done_f;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_e = v;
        else     start_f = v;
    endtask

    task automatic drop_expected(input bit sel);
        if (sel) void'(q_e.pop_back());
        else     void'(q_f.pop_back());
    endtask

    // Called at a negedge with the selected DUT idle
    task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] prod;
        prod      = a * b;
        operand_a = a;
        operand_b = b;
        set_start(sel, 1'b1);
        if (sel) q_e.push_back(prod);
        else     q_f.push_back(prod);
        #1;
        check_eq(sel ? "stall_c0_e" : "stall_c0_f", {31'b0, get_stall(sel)}, 32'd1);
    endtask

    task automatic wait_done(input bit sel, input bit hold, input int k, input string tag);
        int cycles    = 0;
        int stall_cnt = 0;
        logic d, s;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            d = get_done(sel);
            s = get_stall(sel);
            if (!hold) set_start(sel, 1'b0);
            if (d) begin
                cycles = i;
                check_eq({tag, "_stall_in_done"}, {31'b0, s}, 32'd0);
                break;
            end
            if (s) stall_cnt++;
        end
        if (cycles == 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_latency"}, cycles, k + 1);
            check_eq({tag, "_stall_cycles"}, stall_cnt, k);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (done_f) begin
            if (q_f.size() == 0) check_eq("spurious_done_f", 32'd1, 32'd0);
            else begin
                e = q_f.pop_front();
                check_eq("result_f", result_f, e);
            end
        end
        if (done_e) begin
            if (q_e.size() == 0) check_eq("spurious_done_e", 32'd1, 32'd0);
            else begin
                e = q_e.pop_front();
                check_eq("result_e", result_e, e);
            end
        end
    end

    task automatic run_one(input bit sel, input logic [31:0] a, input logic [31:0] b, input string tag);
        launch(sel, a, b);
        wait_done(sel, 1'b0, exp_k(b, sel), tag);
        @(negedge clk);
    endtask

    initial begin
        arst_n    = 1'b0;
        start_f   = 1'b0;
        start_e   = 1'b0;
        flush_f   = 1'b0;
        flush_e   = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        check_eq("rst_stall_f",  {31'b0, stall_f}, 32'd0);
        check_eq("rst_busy_f",   {31'b0, busy_f},  32'd0);
        check_eq("rst_done_f",   {31'b0, done_f},  32'd0);
        check_eq("rst_result_f", result_f,         32'd0);
        check_eq("rst_busy_e",   {31'b0, busy_e},  32'd0);
        check_eq("rst_result_e", result_e,         32'd0);
        @(negedge clk);

        run_one(1'b0, 32'd6, 32'd7, "full_6x7");
        run_one(1'b0, 32'd9, 32'd0, "full_b0");

        run_one(1'b1, 32'd6, 32'd7, "early_6x7");
        check_eq("result_hold_e", result_e, 32'd42);
        run_one(1'b1, 32'd3, 32'h8000_0000, "early_msb");
        run_one(1'b1, 32'd5, 32'd0, "early_b0");
        run_one(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "early_ovf");
        run_one(1'b1, 32'h1234_5678, 32'h0000_0ABC, "early_mix");

        // Flush in cycle 5 of a long run
        launch(1'b1, 32'd6, 32'h0000_FFFF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start_e = 1'b0;
        end
        flush_e = 1'b1;
        #1;
        check_eq("flush_stall", {31'b0, stall_e}, 32'd0);
        check_eq("flush_done",  {31'b0, done_e},  32'd0);
        drop_expected(1'b1);
        @(negedge clk);
        flush_e = 1'b0;
        check_eq("flush_idle_busy",  {31'b0, busy_e},  32'd0);
        check_eq("flush_idle_stall", {31'b0, stall_e}, 32'd0);
        run_one(1'b1, 32'd3, 32'd5, "after_flush");

        // Reset mid-run
        launch(1'b0, 32'd6, 32'd7);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start_f = 1'b0;
        end
        arst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy",   {31'b0, busy_f},  32'd0);
        check_eq("mid_rst_stall",  {31'b0, stall_f}, 32'd0);
        check_eq("mid_rst_done",   {31'b0, done_f},  32'd0);
        check_eq("mid_rst_result", result_f,         32'd0);
        arst_n = 1'b1;
        drop_expected(1'b0);
        run_one(1'b0, 32'd3, 32'd5, "after_rst");

        // Back-to-back with start held through DONE
        launch(1'b1, 32'd2, 32'd3);
        wait_done(1'b1, 1'b1, 2, "b2b_first");
        operand_a = 32'd4;
        operand_b = 32'd5;
        q_e.push_back(32'd20);
        @(negedge clk);
        check_eq("b2b_gap_busy",  {31'b0, busy_e},  32'd0);
        check_eq("b2b_gap_stall", {31'b0, stall_e}, 32'd1);
        check_eq("b2b_gap_done",  {31'b0, done_e},  32'd0);
        wait_done(1'b1, 1'b0, 3, "b2b_second");
        @(negedge clk);
        check_eq("b2b_no_retrigger", {31'b0, busy_e}, 32'd0);

        check_eq("queue_empty", q_f.size() + q_e.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
